// File: rtl/priority_irq_controller_if.sv
// Handshake bundle between the interrupt controller and its servicing agent.
// master: controller side (presents requests, reports service state).
// slave : servicing agent side (accepts requests, signals end of service).
interface priority_irq_controller_if #(
    parameter int ID_W = 3
);
    logic            irq_valid;   // a request is presented on irq_id
    logic [ID_W-1:0] irq_id;      // index of presented / in-service request
    logic            irq_ack;     // agent accepts the presented request
    logic            eoi;         // end-of-service pulse from the agent
    logic            in_service;  // an accepted request is being serviced

    modport master (
        output irq_valid,
        output irq_id,
        output in_service,
        input  irq_ack,
        input  eoi
    );

    modport slave (
        input  irq_valid,
        input  irq_id,
        input  in_service,
        output irq_ack,
        output eoi
    );
endinterface

// File: rtl/priority_irq_controller.sv
// Fixed-priority interrupt scheduler: edge-latched pending, mask, one request in flight.
// Latency: irq_in rise -> pending next edge -> irq_valid one edge later.
// Backpressure: request held on irq_valid until irq_ack; no new issue until eoi or en drop.
module priority_irq_controller #(
    parameter int N    = 8,
    parameter int ID_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_i,
    input  logic [N-1:0]         irq_in_i,
    input  logic                 mask_wr_i,
    input  logic [N-1:0]         mask_data_i,
    output logic [N-1:0]         pending_o,
    priority_irq_controller_if.master svc
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    irq_prev_q;
    logic [N-1:0]    pending_q, pending_d;
    logic [N-1:0]    mask_q, mask_d;
    logic            irq_valid_q, irq_valid_d;
    logic [ID_W-1:0] irq_id_q, irq_id_d;
    logic            in_service_q, in_service_d;

    logic [N-1:0]    rise;
    logic [N-1:0]    eligible;
    logic [N-1:0]    clr_vec;
    logic            any_eligible;
    logic [ID_W-1:0] winner;
    logic            accept;

    // Highest set index wins; the ascending scan lets later (higher) bits overwrite.
    function automatic logic [ID_W-1:0] encode_hi(input logic [N-1:0] v);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) begin
            if (v[i]) begin
                idx = i[ID_W-1:0];
            end
        end
        return idx;
    endfunction

    // Rising-edge detect, eligibility and priority encoding.
    always_comb begin
        rise         = irq_in_i & ~irq_prev_q;
        eligible     = pending_q & ~mask_q;
        any_eligible = |eligible;
        winner       = encode_hi(eligible);
    end

    // Sequencer: issue in IDLE, hold the presented id in REQ, wait for eoi in SERVICE.
    always_comb begin
        state_d      = state_q;
        irq_valid_d  = irq_valid_q;
        irq_id_d     = irq_id_q;
        in_service_d = in_service_q;
        accept       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_i && any_eligible) begin
                    state_d     = ST_REQ;
                    irq_id_d    = winner;
                    irq_valid_d = 1'b1;
                end
            end
            ST_REQ: begin
                // Acceptance beats a simultaneous enable drop.
                if (svc.irq_ack) begin
                    state_d      = ST_SERVICE;
                    irq_valid_d  = 1'b0;
                    in_service_d = 1'b1;
                    accept       = 1'b1;
                end else if (!en_i) begin
                    state_d     = ST_IDLE;
                    irq_valid_d = 1'b0;
                end
            end
            ST_SERVICE: begin
                // Nothing nests: new events just accumulate in pending.
                if (svc.eoi) begin
                    state_d      = ST_IDLE;
                    in_service_d = 1'b0;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                irq_valid_d  = 1'b0;
                in_service_d = 1'b0;
            end
        endcase
    end

    // Pending update: accepted line is cleared, but a fresh edge on it re-sets it.
    always_comb begin
        clr_vec = '0;
        if (accept) begin
            clr_vec[irq_id_q] = 1'b1;
        end
        pending_d = (pending_q & ~clr_vec) | rise;
        mask_d    = mask_wr_i ? mask_data_i : mask_q;
    end

    // Input history, pending and mask registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_prev_q <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
        end else begin
            irq_prev_q <= irq_in_i;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
        end
    end

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            irq_valid_q  <= 1'b0;
            irq_id_q     <= '0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_valid_q  <= irq_valid_d;
            irq_id_q     <= irq_id_d;
            in_service_q <= in_service_d;
        end
    end

    assign pending_o      = pending_q;
    assign svc.irq_valid  = irq_valid_q;
    assign svc.irq_id     = irq_id_q;
    assign svc.in_service = in_service_q;

endmodule

// File: tb/tb_priority_irq_controller.sv
// Bench for priority_irq_controller: per-cycle vectors with expected post-edge outputs,
// queued when driven and compared one time unit after the capturing clock edge.
module tb_priority_irq_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en_i = 1'b0;
    logic [7:0] irq_in_i = '0;
    logic       mask_wr_i = 1'b0;
    logic [7:0] mask_data_i = '0;
    logic [7:0] pending_o;

    priority_irq_controller_if #(.ID_W(3)) bus ();

    priority_irq_controller #(.N(8), .ID_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .irq_in_i    (irq_in_i),
        .mask_wr_i   (mask_wr_i),
        .mask_data_i (mask_data_i),
        .pending_o   (pending_o),
        .svc         (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] irq_in;
        logic       mwr;
        logic [7:0] mdata;
        logic       ack;
        logic       eoi;
        logic       exp_valid;
        logic [2:0] exp_id;
        logic [7:0] exp_pend;
        logic       exp_insvc;
    } vec_t;

    vec_t tbl[20];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t mk(input logic en, input logic [7:0] irq, input logic mwr,
                                input logic [7:0] md, input logic ack, input logic eoi,
                                input logic v, input logic [2:0] id, input logic [7:0] p,
                                input logic s);
        vec_t r;
        r.en = en; r.irq_in = irq; r.mwr = mwr; r.mdata = md; r.ack = ack; r.eoi = eoi;
        r.exp_valid = v; r.exp_id = id; r.exp_pend = p; r.exp_insvc = s;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic v, input logic [2:0] id,
                                 input logic [7:0] p, input logic s);
        check({tag, ".irq_valid"},  {7'd0, bus.irq_valid},  {7'd0, v});
        check({tag, ".irq_id"},     {5'd0, bus.irq_id},     {5'd0, id});
        check({tag, ".pending"},    pending_o,              p);
        check({tag, ".in_service"}, {7'd0, bus.in_service}, {7'd0, s});
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        @(negedge clk);
        en_i        = v.en;
        irq_in_i    = v.irq_in;
        mask_wr_i   = v.mwr;
        mask_data_i = v.mdata;
        bus.irq_ack = v.ack;
        bus.eoi     = v.eoi;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_outputs(tag, e.exp_valid, e.exp_id, e.exp_pend, e.exp_insvc);
    endtask

    initial begin
        bus.irq_ack = 1'b0;
        bus.eoi     = 1'b0;

        //            en irq    mwr md    ack eoi  v  id  pend  svc
        // single line 0 through the full handshake
        tbl[0]  = mk(1, 8'h00, 1, 8'h00, 0, 0,   0, 0, 8'h00, 0);
        tbl[1]  = mk(1, 8'h01, 0, 8'h00, 0, 0,   0, 0, 8'h01, 0);
        tbl[2]  = mk(1, 8'h00, 0, 8'h00, 0, 0,   1, 0, 8'h01, 0);
        tbl[3]  = mk(1, 8'h00, 0, 8'h00, 1, 0,   0, 0, 8'h00, 1);
        tbl[4]  = mk(1, 8'h00, 0, 8'h00, 0, 1,   0, 0, 8'h00, 0);
        tbl[5]  = mk(1, 8'h00, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0);
        // four lines at once, served 3,2,1,0 with an idle cycle after each eoi
        tbl[6]  = mk(1, 8'h0F, 0, 8'h00, 0, 0,   0, 0, 8'h0F, 0);
        tbl[7]  = mk(1, 8'h0F, 0, 8'h00, 0, 0,   1, 3, 8'h0F, 0);
        tbl[8]  = mk(1, 8'h0F, 0, 8'h00, 1, 0,   0, 3, 8'h07, 1);
        tbl[9]  = mk(1, 8'h0F, 0, 8'h00, 0, 1,   0, 3, 8'h07, 0);
        tbl[10] = mk(1, 8'h0F, 0, 8'h00, 0, 0,   1, 2, 8'h07, 0);
        tbl[11] = mk(1, 8'h0F, 0, 8'h00, 1, 0,   0, 2, 8'h03, 1);
        tbl[12] = mk(1, 8'h0F, 0, 8'h00, 0, 1,   0, 2, 8'h03, 0);
        tbl[13] = mk(1, 8'h0F, 0, 8'h00, 0, 0,   1, 1, 8'h03, 0);
        tbl[14] = mk(1, 8'h0F, 0, 8'h00, 1, 0,   0, 1, 8'h01, 1);
        tbl[15] = mk(1, 8'h0F, 0, 8'h00, 0, 1,   0, 1, 8'h01, 0);
        tbl[16] = mk(1, 8'h0F, 0, 8'h00, 0, 0,   1, 0, 8'h01, 0);
        tbl[17] = mk(1, 8'h0F, 0, 8'h00, 1, 0,   0, 0, 8'h00, 1);
        tbl[18] = mk(1, 8'h0F, 0, 8'h00, 0, 1,   0, 0, 8'h00, 0);
        tbl[19] = mk(1, 8'h0F, 0, 8'h00, 0, 0,   0, 0, 8'h00, 0);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 0, 0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            step(tbl[i], $sformatf("tbl%0d", i));
        end

        // mask hides line 3; unmasking during service makes 3 the next winner
        step(mk(1, 8'h00, 1, 8'h08, 0, 0, 0, 0, 8'h00, 0), "msk0");
        step(mk(1, 8'h0F, 0, 8'h00, 0, 0, 0, 0, 8'h0F, 0), "msk1");
        step(mk(1, 8'h0F, 0, 8'h00, 0, 0, 1, 2, 8'h0F, 0), "msk2");
        step(mk(1, 8'h0F, 0, 8'h00, 1, 0, 0, 2, 8'h0B, 1), "msk3");
        step(mk(1, 8'h0F, 1, 8'h00, 0, 0, 0, 2, 8'h0B, 1), "msk4");
        step(mk(1, 8'h0F, 0, 8'h00, 0, 1, 0, 2, 8'h0B, 0), "msk5");
        step(mk(1, 8'h0F, 0, 8'h00, 0, 0, 1, 3, 8'h0B, 0), "msk6");
        step(mk(1, 8'h0F, 0, 8'h00, 1, 0, 0, 3, 8'h03, 1), "msk7");
        step(mk(1, 8'h0F, 0, 8'h00, 0, 1, 0, 3, 8'h03, 0), "msk8");
        // presented id 1 is not re-arbitrated when line 7 arrives
        step(mk(1, 8'h0F, 0, 8'h00, 0, 0, 1, 1, 8'h03, 0), "hold0");
        step(mk(1, 8'h8F, 0, 8'h00, 0, 0, 1, 1, 8'h83, 0), "hold1");
        step(mk(1, 8'h8F, 0, 8'h00, 0, 0, 1, 1, 8'h83, 0), "hold2");
        step(mk(1, 8'h8F, 0, 8'h00, 1, 0, 0, 1, 8'h81, 1), "hold3");
        step(mk(1, 8'h8F, 0, 8'h00, 0, 1, 0, 1, 8'h81, 0), "hold4");
        step(mk(1, 8'h8F, 0, 8'h00, 0, 0, 1, 7, 8'h81, 0), "hold5");
        step(mk(1, 8'h8F, 0, 8'h00, 1, 0, 0, 7, 8'h01, 1), "hold6");
        step(mk(1, 8'h8F, 0, 8'h00, 0, 1, 0, 7, 8'h01, 0), "hold7");
        step(mk(1, 8'h8F, 0, 8'h00, 0, 0, 1, 0, 8'h01, 0), "hold8");
        step(mk(1, 8'h8F, 0, 8'h00, 1, 0, 0, 0, 8'h00, 1), "hold9");
        step(mk(1, 8'h8F, 0, 8'h00, 0, 1, 0, 0, 8'h00, 0), "hold10");
        // enable gating, withdrawal before ack, and ack beating en=0
        step(mk(0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0), "en0");
        step(mk(0, 8'h10, 0, 8'h00, 0, 0, 0, 0, 8'h10, 0), "en1");
        step(mk(0, 8'h10, 0, 8'h00, 0, 0, 0, 0, 8'h10, 0), "en2");
        step(mk(1, 8'h10, 0, 8'h00, 0, 0, 1, 4, 8'h10, 0), "en3");
        step(mk(0, 8'h10, 0, 8'h00, 0, 0, 0, 4, 8'h10, 0), "en4");
        step(mk(1, 8'h10, 0, 8'h00, 0, 0, 1, 4, 8'h10, 0), "en5");
        step(mk(0, 8'h10, 0, 8'h00, 1, 0, 0, 4, 8'h00, 1), "en6");

        // asynchronous reset while in service takes effect without a clock edge
        @(negedge clk);
        bus.irq_ack = 1'b0;
        rst = 1'b1;
        #1;
        check_outputs("midrst", 0, 0, 8'h00, 0);
        @(negedge clk);
        rst = 1'b0;
        // held line registers once after reset; mask is all-ones so nothing issues;
        // stray eoi/ack while idle do nothing
        step(mk(1, 8'h10, 0, 8'h00, 1, 1, 0, 0, 8'h10, 0), "post0");
        step(mk(1, 8'h10, 0, 8'h00, 1, 1, 0, 0, 8'h10, 0), "post1");
        step(mk(1, 8'h10, 1, 8'h00, 0, 0, 0, 0, 8'h10, 0), "post2");
        step(mk(1, 8'h10, 0, 8'h00, 0, 0, 1, 4, 8'h10, 0), "post3");
        step(mk(1, 8'h10, 0, 8'h00, 1, 0, 0, 4, 8'h00, 1), "post4");
        step(mk(1, 8'h10, 0, 8'h00, 0, 1, 0, 4, 8'h00, 0), "post5");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/priority_irq_controller.md
Name: priority_irq_controller

Overview:
Sequencing controller built around an 8-input fixed-priority encoder (highest index wins; 8'b0000_1111 selects 3).
- Latches rising edges on eight request lines into a pending register and applies a per-line mask.
- Presents one winning request at a time to a downstream servicing agent using a valid/ack handshake.
- Holds that request in service until an end-of-interrupt (eoi) pulse is received.
- Sits between raw event sources and the single shared servicing resource; it is the scheduler for that resource.

Parameters:
N, 8, number of request lines (fixed at 8 for this revision).
ID_W, 3, width of the request index; N == 2**ID_W.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous active-high reset
en  input  1  global enable; when low, no new request is issued
irq_in  input  N  level request lines; a rising edge creates a pending event
mask_wr  input  1  write strobe for the mask register
mask_data  input  N  new mask value; bit=1 disables that line
irq_valid  output  1  a request is presented on irq_id
irq_id  output  ID_W  index of the presented or in-service request
irq_ack  input  1  servicing agent accepts the presented request
eoi  input  1  end of service pulse
pending  output  N  current pending register
in_service  output  1  an accepted request is being serviced

Behaviour:
- Reset (async, rst=1):
  - irq_valid=0, irq_id=0, in_service=0, pending=0.
  - mask=8'hFF (all lines disabled), irq_prev=0, FSM=IDLE.
- Edge detect:
  - irq_prev <= irq_in every cycle.
  - pending[i] is set at the edge where irq_in[i]=1 and irq_prev[i]=0.
  - A line held high through reset release registers one event on the first edge.
- Pending clear: pending[irq_id] is cleared at the edge where the FSM is in REQ and irq_ack=1. If a new edge on the same line coincides with the clear, the set wins.
- Mask:
  - mask <= mask_data at the edge where mask_wr=1.
  - Masking never clears pending; eligible = pending & ~mask.
- Encoder: winner = highest set index of eligible. No winner when eligible == 0.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if en=1 and eligible != 0, go to REQ at the next edge, registering irq_id <= winner and irq_valid <= 1. Otherwise stay.
  - REQ:
    - irq_valid=1 and irq_id is held stable; it is not re-arbitrated even if a higher-priority line arrives or the line becomes masked.
    - irq_ack=1: go to SERVICE, irq_valid <= 0, in_service <= 1, clear pending[irq_id].
    - irq_ack=0 and en=0: go to IDLE, irq_valid <= 0; pending is kept.
    - irq_ack has priority over en=0 in the same cycle.
  - SERVICE: irq_id is held. eoi=1 goes to IDLE with in_service <= 0. No nesting: pending events accumulate but are not presented.
- Ignored inputs: irq_ack outside REQ; eoi outside SERVICE.
- Latency:
  - The edge sampling irq_in rising sets pending.
  - irq_valid asserts one edge later (FSM idle, en=1, line unmasked).
  - After eoi, at least one IDLE cycle precedes the next irq_valid.
- Reset mid-operation: returns to the reset state immediately; in-flight requests are dropped.

Test Plan:
1. Reset, then mask_wr with mask_data=8'h00. Pulse irq_in[0] -> pending=8'h01 after one edge; next edge irq_valid=1, irq_id=0. Ack -> in_service=1, pending=0. eoi -> IDLE.
2. mask=8'h00; raise irq_in=8'b0000_1111 in one cycle -> pending=8'h0F, irq_id=3. After ack+eoi the next requests are 2, then 1, then 0 in order; pending ends at 0.
3. mask=8'h08; pending=8'h0F -> first irq_id=2. Write mask=8'h00 while in SERVICE -> after eoi, irq_id=3 is next.
4. irq_valid=1 with irq_id=1; raise irq_in[7] before ack -> irq_id stays 1 until ack. After eoi, irq_id=7.
5. en=0 with pending=8'h10 -> irq_valid stays 0. en=1 -> irq_valid=1, irq_id=4. Drop en=0 before ack -> irq_valid=0, pending still 8'h10.
6. Assert rst during SERVICE -> in_service=0, irq_valid=0, pending=0, mask=8'hFF at once. Stray eoi and irq_ack in IDLE -> no change.
